serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial unsigned adder; the addition-direction counterpart of the half-subtractor in the arithmetic primitives set. Captures two WIDTH-bit operands on a start request, adds them LSB-first one bit per clock through a single full-adder cell and a carry flip-flop, then presents the sum and carry-out with a one-cycle done pulse. Used where area matters more than latency; it also exercises the bit-cell library under sequential control.

## Interface
- WIDTH, 8, operand/sum width in bits; legal range 1..32
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  augend, captured on accepted start
- b  input  WIDTH  addend, captured on accepted start
- busy  output  1  high while an addition is in progress
- done  output  1  single-cycle pulse: sum/cout valid and updated
- sum  output  WIDTH  result, held until next completion
- cout  output  1  carry-out of MSB, held with sum

## Operation
- Reset (rst_n=0, asynchronous, at any time including mid-operation): state=IDLE, busy=0, done=0, sum=0, cout=0, bit counter=0, carry=0, operand shift registers=0.
- FSM states: IDLE, RUN.
- IDLE: if start=1 at a rising edge, load a/b into shift registers, counter=0, carry=0, go to RUN. start=0: stay.
- RUN: each edge, full_add(a_sr[0], b_sr[0], carry) -> s, c; carry<=c; shift s into result register from MSB side; shift a_sr/b_sr right by one; counter++.
- On the edge processing bit WIDTH-1: sum<=complete result, cout<=final carry, done<=1, state<=IDLE.
- done is 1 for exactly one cycle after each completion; 0 otherwise.
- start while busy=1: ignored; a/b changes during RUN have no effect.
- Arithmetic: sum = (a+b) mod 2^WIDTH, cout = bit WIDTH of a+b; unsigned, no overflow flag.
- sum/cout are not modified during RUN; they change only on completion or reset.

## Timing
- Accepted start at edge E: busy=1 from E until edge E+WIDTH; busy=0 after E+WIDTH.
- done=1, sum/cout valid in the cycle following edge E+WIDTH (latency WIDTH cycles from accepted start edge).
- Back-to-back: start held high during the done cycle is accepted at the next edge (busy=0 then); throughput one result per WIDTH+1 cycles.
- WIDTH=1: RUN lasts one edge; done one cycle after the start edge.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package serial_arith_pkg: state enum type (IDLE, RUN), counter width constant derived with $clog2(WIDTH+1) as a function.
- One sub-module: full_add (combinational a, b, cin -> s, cout), built as two half-adders plus OR; instantiated once in serial_adder.
- Top holds FSM, counter, carry flop, operand and result shift registers.

## Test plan (WIDTH=8 unless noted)
- Reset then a=0x00, b=0x00, start 1 cycle -> busy 8 cycles, done pulse at cycle 8, sum=0x00, cout=0.
- a=0xFF, b=0x01 -> sum=0x00, cout=1; then a=0xA5, b=0x5A -> sum=0xFF, cout=0; sum stays 0x00 during the second RUN.
- Start accepted with a=0x10, b=0x20; at cycle 3 pulse start with a=0xFF, b=0xFF and change a/b -> ignored; result 0x30, cout=0, exactly one done pulse.
- Start with a=0x80, b=0x80; assert rst_n=0 at cycle 4 -> busy, done, sum, cout immediately 0; after release no done until a new start.
- start held high continuously with a=0x01, b=0x02 -> done every 9 cycles, sum=0x03 each time.
- WIDTH=1: all four a/b combinations -> (sum,cout) = (0,0), (1,0), (1,0), (0,1), done one cycle after start edge.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared types and sizing helpers for the bit-serial arithmetic blocks
package serial_arith_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/full_add.sv
// full_add: one-bit full adder built from two half-adders and an OR
module full_add (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic hs, hc1, hc2;
  assign hs   = a ^ b;
  assign hc1  = a & b;
  assign s    = hs ^ cin;
  assign hc2  = hs & cin;
  assign cout = hc1 | hc2;
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial unsigned adder with one full-adder cell and a carry flop
module serial_adder
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = cnt_w(WIDTH);
  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_sr, b_sr, r_sr, r_next;
  logic             s, c, last;
  full_add u_fa (.a(a_sr[0]), .b(b_sr[0]), .cin(carry), .s(s), .cout(c));
  // new sum bit enters from the MSB side so the LSB lands at bit 0 after WIDTH shifts
  always_comb begin
    r_next = (r_sr >> 1) | (WIDTH'(s) << (WIDTH - 1));
    last   = cnt == CW'(WIDTH - 1);
  end
  // FSM, operand/result shifting and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      cnt   <= '0;
      carry <= 1'b0;
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          a_sr  <= a;
          b_sr  <= b;
          r_sr  <= '0;
          cnt   <= '0;
          carry <= 1'b0;
          busy  <= 1'b1;
          state <= RUN;
        end
      end else begin
        carry <= c;
        r_sr  <= r_next;
        a_sr  <= a_sr >> 1;
        b_sr  <= b_sr >> 1;
        cnt   <= cnt + CW'(1);
        if (last) begin
          sum   <= r_next;
          cout  <= c;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: table-driven, hand-sequenced and randomized checks of serial_adder
module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, cout;
  logic [7:0] sum;
  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;
  int checks = 0, errors = 0;

  serial_adder #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       c;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // one full transaction on the 8-bit instance, checked against expected sum/carry
  task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic [7:0] es,
                      input logic ec, input string nm);
    logic [7:0] prev;
    int lat;
    bit got, held;
    prev = sum;
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({nm, " busy"}, busy, 1);
    lat = 0; got = 0; held = 1;
    repeat (20) begin
      if (!got) begin
        @(negedge clk);
        lat++;
        if (done) got = 1;
        else if (sum !== prev) held = 0;
      end
    end
    chk({nm, " latency"}, lat, 8);
    chk({nm, " sum"}, sum, es);
    chk({nm, " cout"}, cout, ec);
    chk({nm, " held"}, held, 1);
    chk({nm, " busy_end"}, busy, 0);
    @(negedge clk);
    chk({nm, " done_pulse"}, done, 0);
  endtask

  initial begin
    vec_t tbl[4];
    logic [8:0] m;
    int pulses, last_t, t;
    bit ok_iv, ok_s;
    tbl[0] = '{8'h00, 8'h00, 8'h00, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    tbl[2] = '{8'hA5, 8'h5A, 8'hFF, 1'b0};
    tbl[3] = '{8'h7F, 8'h81, 8'h00, 1'b1};

    repeat (2) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst sum", sum, 0);
    chk("rst cout", cout, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) run8(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].c, $sformatf("tbl%0d", i));

    // start while busy must be ignored
    @(negedge clk);
    a = 8'h10; b = 8'h20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'h33; b = 8'h44;
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        chk("ign sum", sum, 8'h30);
        chk("ign cout", cout, 0);
      end
    end
    chk("ign pulses", pulses, 1);

    // asynchronous reset mid-operation
    a = 8'h80; b = 8'h80; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst busy", busy, 0);
    chk("arst done", done, 0);
    chk("arst sum", sum, 0);
    chk("arst cout", cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("arst no_done", pulses, 0);

    // start held high: one result every WIDTH+1 cycles
    a = 8'h01; b = 8'h02; start = 1'b1;
    pulses = 0; last_t = -1; ok_iv = 1; ok_s = 1;
    for (t = 0; t < 40; t++) begin
      @(negedge clk);
      if (done) begin
        if (sum !== 8'h03 || cout !== 1'b0) ok_s = 0;
        if (last_t >= 0 && t - last_t != 9) ok_iv = 0;
        last_t = t;
        pulses++;
      end
    end
    start = 1'b0;
    chk("b2b pulses", pulses, 4);
    chk("b2b interval", ok_iv, 1);
    chk("b2b sum", ok_s, 1);
    repeat (10) @(negedge clk);

    // WIDTH=1: all four operand combinations
    for (int i = 0; i < 4; i++) begin
      a1 = 1'(i); b1 = 1'(i >> 1); start1 = 1'b1;
      m = 9'(a1) + 9'(b1);
      @(negedge clk);
      start1 = 1'b0;
      chk($sformatf("w1 busy%0d", i), busy1, 1);
      chk($sformatf("w1 early%0d", i), done1, 0);
      @(negedge clk);
      chk($sformatf("w1 done%0d", i), done1, 1);
      chk($sformatf("w1 sum%0d", i), sum1, m[0]);
      chk($sformatf("w1 cout%0d", i), cout1, m[1]);
      @(negedge clk);
      chk($sformatf("w1 pulse%0d", i), done1, 0);
    end

    // random operands against plain-arithmetic model
    for (int i = 0; i < 20; i++) begin
      logic [7:0] x, y;
      x = 8'($urandom);
      y = 8'($urandom);
      m = {1'b0, x} + {1'b0, y};
      run8(x, y, m[7:0], m[8], $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
